// File: rtl/biss_pkg.sv
// Shared definitions for the BiSS-C polling path.
//   - FSM state encoding of the poll scheduler
//   - default position / CRC widths
//   - bit positions of the active-low {nError, nWarn} status pair
package biss_pkg;

    localparam int DATA_W_DEF = 26;
    localparam int CRC_W_DEF  = 6;

    localparam int NERR  = 1;
    localparam int NWARN = 0;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_TRIG        = 3'd1,
        ST_WAIT        = 3'd2,
        ST_CHECK       = 3'd3,
        ST_FAIL        = 3'd4,
        ST_GAP         = 3'd5,
        ST_PERIOD_WAIT = 3'd6
    } state_t;

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at 16'hFFFF.
//   clk, rst : clock, synchronous active-high reset (clears the count)
//   inc      : count one event this cycle
//   cnt      : current count
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 16'd0;
        end else if (inc && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/biss_poll_scheduler.sv
// Periodic acquisition sequencer for the BiSS-C master. Issues trig pulses on
// a programmable schedule, validates each frame by CRC and timeout, retries
// failed frames within a per-slot budget and publishes validated positions.
//   clk, rst              : clock, synchronous active-high reset
//   enable, single        : periodic run level / one-shot slot request
//   trig, frame_done      : start pulse to master / frame finished pulse
//   pos_in, err_in        : received position and {nError, nWarn}
//   crc_rx, crc_calc      : received and locally computed CRC
//   pos_out, pos_valid    : last validated position and its update strobe
//   enc_error, enc_warn   : encoder status of the last validated frame
//   fault, fault_clr      : sticky retry-exhausted flag and its clear
//   busy                  : slot in progress
//   crc_err_cnt, tmo_cnt  : saturating CRC-mismatch / timeout counts
//
// state          | meaning
// ST_IDLE        | stopped, waiting for enable or single
// ST_TRIG        | trig pulse out, timers loaded
// ST_WAIT        | waiting for frame_done or timeout
// ST_CHECK       | act on CRC result captured with frame_done
// ST_FAIL        | consume one retry or raise fault
// ST_GAP         | slave recovery time after frame end / timeout
// ST_PERIOD_WAIT | waiting for the poll period to expire
module biss_poll_scheduler
    import biss_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CRC_W       = CRC_W_DEF,
    parameter int PERIOD_CYC  = 5000,
    parameter int TIMEOUT_CYC = 2000,
    parameter int GAP_CYC     = 200,
    parameter int MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              single,
    output logic              trig,
    input  logic              frame_done,
    input  logic [DATA_W-1:0] pos_in,
    input  logic [1:0]        err_in,
    input  logic [CRC_W-1:0]  crc_rx,
    input  logic [CRC_W-1:0]  crc_calc,
    output logic [DATA_W-1:0] pos_out,
    output logic              pos_valid,
    output logic              enc_error,
    output logic              enc_warn,
    output logic              fault,
    input  logic              fault_clr,
    output logic              busy,
    output logic [15:0]       crc_err_cnt,
    output logic [15:0]       tmo_cnt
);

    localparam int PW = $clog2(PERIOD_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    // Period and timeout timers are loaded in TRIG, one cycle after the trig
    // edge they are measured from; the gap timer is loaded on the frame-end /
    // timeout cycle itself so CHECK and FAIL count toward the recovery gap.
    localparam logic [PW-1:0] PER_LOAD = PW'(PERIOD_CYC - 2);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);
    localparam logic [RW-1:0] MAX_R    = RW'(MAX_RETRY);

    state_t          state;
    logic [PW-1:0]   per_t;
    logic [TW-1:0]   tmo_t;
    logic [GW-1:0]   gap_t;
    logic [RW-1:0]   retry;
    logic            retry_pend;
    logic            crc_ok;
    logic            crc_inc;
    logic            tmo_inc;

    assign crc_inc = (state == ST_CHECK) && !crc_ok;
    assign tmo_inc = (state == ST_WAIT) && !frame_done && (tmo_t == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            trig       <= 1'b0;
            pos_out    <= '0;
            pos_valid  <= 1'b0;
            enc_error  <= 1'b0;
            enc_warn   <= 1'b0;
            fault      <= 1'b0;
            busy       <= 1'b0;
            retry      <= '0;
            retry_pend <= 1'b0;
            crc_ok     <= 1'b0;
            per_t      <= '0;
            tmo_t      <= '0;
            gap_t      <= '0;
        end else begin
            trig      <= 1'b0;
            pos_valid <= 1'b0;
            if (per_t != '0) per_t <= per_t - PW'(1);
            if (tmo_t != '0) tmo_t <= tmo_t - TW'(1);
            if (gap_t != '0) gap_t <= gap_t - GW'(1);
            if (fault_clr) fault <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (enable || single) begin
                        state <= ST_TRIG;
                        trig  <= 1'b1;
                        busy  <= 1'b1;
                        retry <= '0;
                    end
                end
                ST_TRIG: begin
                    tmo_t      <= TMO_LOAD;
                    per_t      <= PER_LOAD;
                    retry_pend <= 1'b0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    // frame_done is tested first so it wins on the expiry cycle
                    if (frame_done) begin
                        crc_ok <= (crc_rx == crc_calc);
                        gap_t  <= GAP_LOAD;
                        state  <= ST_CHECK;
                        // publish here so pos_valid lands the cycle after frame_done
                        if (crc_rx == crc_calc) begin
                            pos_out   <= pos_in;
                            enc_error <= !err_in[NERR];
                            enc_warn  <= !err_in[NWARN];
                            pos_valid <= 1'b1;
                        end
                    end else if (tmo_t == '0) begin
                        gap_t <= GAP_LOAD;
                        state <= ST_FAIL;
                    end
                end
                ST_CHECK: begin
                    state <= crc_ok ? ST_GAP : ST_FAIL;
                end
                ST_FAIL: begin
                    if (retry < MAX_R) begin
                        retry      <= retry + RW'(1);
                        retry_pend <= 1'b1;
                    end else if (!fault_clr) begin
                        fault <= 1'b1;
                    end
                    state <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_t == '0) begin
                        if (retry_pend) begin
                            state <= ST_TRIG;
                            trig  <= 1'b1;
                        end else begin
                            state <= ST_PERIOD_WAIT;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_PERIOD_WAIT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (per_t == '0) begin
                        state <= ST_TRIG;
                        trig  <= 1'b1;
                        busy  <= 1'b1;
                        retry <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    sat_cnt16 u_crc_cnt (
        .clk (clk),
        .rst (rst),
        .inc (crc_inc),
        .cnt (crc_err_cnt)
    );

    sat_cnt16 u_tmo_cnt (
        .clk (clk),
        .rst (rst),
        .inc (tmo_inc),
        .cnt (tmo_cnt)
    );

endmodule

// File: tb/tb_biss_poll_scheduler.sv
// Bench for biss_poll_scheduler. A slot-level model predicts each trigger
// time from the scheduling rules (retry at event+GAP+1, next slot at
// max(trig+PERIOD, event+GAP+2)), plus counters, fault and published data.
module tb_biss_poll_scheduler;

    localparam int DATA_W    = 26;
    localparam int CRC_W     = 6;
    localparam int PERIOD    = 100;
    localparam int TIMEOUT   = 40;
    localparam int GAP       = 10;
    localparam int MAX_RETRY = 3;

    localparam int K_GOOD = 0;
    localparam int K_CRC  = 1;
    localparam int K_TMO  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              single = 1'b0;
    logic              frame_done = 1'b0;
    logic              fault_clr = 1'b0;
    logic [DATA_W-1:0] pos_in = '0;
    logic [1:0]        err_in = 2'b11;
    logic [CRC_W-1:0]  crc_rx = '0;
    logic [CRC_W-1:0]  crc_calc = '0;
    logic              trig;
    logic [DATA_W-1:0] pos_out;
    logic              pos_valid;
    logic              enc_error;
    logic              enc_warn;
    logic              fault;
    logic              busy;
    logic [15:0]       crc_err_cnt;
    logic [15:0]       tmo_cnt;

    int cyc = 0;
    int trig_seen = 0;
    int pv_seen = 0;
    int n_tests = 0;
    int n_fail = 0;

    // reference model
    int                exp_t = 0;
    int                m_trigs = 0;
    int                m_pv = 0;
    int                m_retry = 0;
    int                m_crc = 0;
    int                m_tmo = 0;
    bit                m_fault = 1'b0;
    logic [DATA_W-1:0] m_pos = '0;
    bit                m_err = 1'b0;
    bit                m_warn = 1'b0;

    biss_poll_scheduler #(
        .DATA_W      (DATA_W),
        .CRC_W       (CRC_W),
        .PERIOD_CYC  (PERIOD),
        .TIMEOUT_CYC (TIMEOUT),
        .GAP_CYC     (GAP),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .single      (single),
        .trig        (trig),
        .frame_done  (frame_done),
        .pos_in      (pos_in),
        .err_in      (err_in),
        .crc_rx      (crc_rx),
        .crc_calc    (crc_calc),
        .pos_out     (pos_out),
        .pos_valid   (pos_valid),
        .enc_error   (enc_error),
        .enc_warn    (enc_warn),
        .fault       (fault),
        .fault_clr   (fault_clr),
        .busy        (busy),
        .crc_err_cnt (crc_err_cnt),
        .tmo_cnt     (tmo_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (trig === 1'b1) trig_seen <= trig_seen + 1;
        if (pos_valid === 1'b1) pv_seen <= pv_seen + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish (n_tests=%0d)", n_tests);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Looks at the current cycle first, then advances one cycle at a time.
    task automatic wait_trig(output int t);
        t = -1;
        for (int k = 0; k < 400; k++) begin
            if (trig === 1'b1) begin
                t = cyc;
                break;
            end
            step();
        end
        if (t < 0) chk("trig_wait", trig, 1'b1);
    endtask

    task automatic check_reset_vals();
        chk("rst_trig", trig, 1'b0);
        chk("rst_pos_out", pos_out, '0);
        chk("rst_pos_valid", pos_valid, 1'b0);
        chk("rst_enc_error", enc_error, 1'b0);
        chk("rst_enc_warn", enc_warn, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_crc_cnt", crc_err_cnt, 16'd0);
        chk("rst_tmo_cnt", tmo_cnt, 16'd0);
    endtask

    task automatic model_reset();
        m_retry = 0;
        m_crc   = 0;
        m_tmo   = 0;
        m_fault = 1'b0;
        m_pos   = '0;
        m_err   = 1'b0;
        m_warn  = 1'b0;
    endtask

    // One attempt: wait for its trig, answer as the master would, update model.
    task automatic do_attempt(input int kind, input int f, input logic [DATA_W-1:0] pos,
                              input logic [1:0] err, input bit late, input bit clr);
        int t;
        int e;
        logic [CRC_W-1:0] c;
        wait_trig(t);
        chk("trig_time", t, exp_t);
        chk("busy_at_trig", busy, 1'b1);
        chk("trig_count", trig_seen, m_trigs);
        chk("pv_count", pv_seen, m_pv);
        chk("crc_err_cnt", crc_err_cnt, m_crc);
        chk("tmo_cnt", tmo_cnt, m_tmo);
        chk("fault", fault, m_fault);
        chk("pos_out_hold", pos_out, m_pos);
        m_trigs++;
        c = CRC_W'($urandom);
        if (kind != K_TMO) begin
            repeat (f) step();
            frame_done = 1'b1;
            pos_in     = pos;
            err_in     = err;
            crc_rx     = c;
            crc_calc   = (kind == K_GOOD) ? c : (c ^ CRC_W'($urandom_range(1, 63)));
            step();
            frame_done = 1'b0;
            pos_in     = DATA_W'($urandom);
            e = t + f;
            if (kind == K_GOOD) begin
                m_pos  = pos;
                m_err  = !err[1];
                m_warn = !err[0];
                m_pv++;
            end
            chk("pos_valid", pos_valid, kind == K_GOOD);
            chk("pos_out", pos_out, m_pos);
            chk("enc_error", enc_error, m_err);
            chk("enc_warn", enc_warn, m_warn);
        end else begin
            repeat (TIMEOUT + 1) step();
            if (clr) fault_clr = 1'b1;
            step();
            fault_clr = 1'b0;
            repeat (2) step();
            if (late) begin
                frame_done = 1'b1;
                pos_in     = pos;
                err_in     = err;
                crc_rx     = c;
                crc_calc   = c;
                step();
                frame_done = 1'b0;
                chk("late_frame_ignored", pos_valid, 1'b0);
            end
            e = t + TIMEOUT;
        end
        if (kind == K_CRC) m_crc = sat16(m_crc + 1);
        if (kind == K_TMO) m_tmo = sat16(m_tmo + 1);
        if (kind == K_GOOD) begin
            m_retry = 0;
            exp_t   = imax(t + PERIOD, e + GAP + 2);
        end else if (m_retry < MAX_RETRY) begin
            m_retry++;
            exp_t = e + GAP + 1;
            if (clr) m_fault = 1'b0;
        end else begin
            m_retry = 0;
            m_fault = !clr;
            exp_t   = imax(t + PERIOD, e + GAP + 2);
        end
    endtask

    initial begin
        int t;
        int kind;
        int f;

        // reset state
        repeat (3) step();
        rst = 1'b0;
        check_reset_vals();
        repeat (5) step();
        chk("idle_no_trig", trig_seen, 0);

        // good periodic frames
        enable = 1'b1;
        exp_t  = cyc + 1;
        for (int i = 0; i < 4; i++) do_attempt(K_GOOD, 20, 26'h155AAAA, 2'b11, 1'b0, 1'b0);

        // one CRC mismatch followed by a good retry
        do_attempt(K_CRC, 20, 26'h0ABCDEF, 2'b11, 1'b0, 1'b0);
        do_attempt(K_GOOD, 20, 26'h155AAAA, 2'b11, 1'b0, 1'b0);

        // persistent timeout exhausts the retry budget
        for (int i = 0; i < 4; i++) do_attempt(K_TMO, 0, '0, 2'b11, 1'b0, 1'b0);
        do_attempt(K_GOOD, 33, 26'h2345678, 2'b11, 1'b0, 1'b0);

        // late frame_done after a timeout, then a boundary-cycle frame
        do_attempt(K_TMO, 0, 26'h3FFFFFF, 2'b11, 1'b1, 1'b0);
        do_attempt(K_GOOD, TIMEOUT, 26'h1111111, 2'b11, 1'b0, 1'b0);

        // encoder error bit, then fault clear alone and against a fault set
        do_attempt(K_GOOD, 7, 26'h0C0FFEE, 2'b01, 1'b0, 1'b0);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        m_fault   = 1'b0;
        chk("fault_clr_alone", fault, 1'b0);
        for (int i = 0; i < 3; i++) do_attempt(K_TMO, 0, '0, 2'b11, 1'b0, 1'b0);
        do_attempt(K_TMO, 0, '0, 2'b11, 1'b0, 1'b1);
        do_attempt(K_GOOD, 1, 26'h0000001, 2'b10, 1'b0, 1'b0);

        // randomized schedule
        for (int i = 0; i < 40; i++) begin
            kind = ($urandom_range(0, 3) < 2) ? K_GOOD : (($urandom_range(0, 1) == 0) ? K_CRC : K_TMO);
            f    = ($urandom_range(0, 4) == 0) ? TIMEOUT : int'($urandom_range(1, TIMEOUT));
            do_attempt(kind, f, DATA_W'($urandom), 2'($urandom),
                       (kind == K_TMO) && ($urandom_range(0, 2) == 0),
                       (kind == K_TMO) && ($urandom_range(0, 3) == 0));
        end
        do_attempt(K_GOOD, 12, DATA_W'($urandom), 2'b11, 1'b0, 1'b0);

        // enable falls mid-slot: retries still run, then the block stops
        do_attempt(K_TMO, 0, '0, 2'b11, 1'b0, 1'b0);
        enable = 1'b0;
        do_attempt(K_TMO, 0, '0, 2'b11, 1'b0, 1'b0);
        do_attempt(K_GOOD, 15, 26'h2AAAAAA, 2'b11, 1'b0, 1'b0);
        repeat (150) step();
        chk("stop_after_slot_trigs", trig_seen, m_trigs);
        chk("stop_after_slot_busy", busy, 1'b0);

        // single-shot slot while disabled
        single = 1'b1;
        exp_t  = cyc + 1;
        step();
        single = 1'b0;
        do_attempt(K_GOOD, 25, 26'h1234567, 2'b00, 1'b0, 1'b0);
        repeat (150) step();
        chk("single_one_slot_trigs", trig_seen, m_trigs);
        chk("single_idle_busy", busy, 1'b0);

        // rst while waiting for a frame
        enable = 1'b1;
        exp_t  = cyc + 1;
        wait_trig(t);
        chk("rst_test_trig_time", t, exp_t);
        m_trigs++;
        repeat (5) step();
        rst    = 1'b1;
        enable = 1'b0;
        step();
        rst = 1'b0;
        model_reset();
        check_reset_vals();
        repeat (30) step();
        chk("no_trig_after_rst", trig_seen, m_trigs);
        enable = 1'b1;
        exp_t  = cyc + 1;
        do_attempt(K_GOOD, 20, 26'h155AAAA, 2'b11, 1'b0, 1'b0);
        do_attempt(K_GOOD, 20, 26'h0F0F0F0, 2'b11, 1'b0, 1'b0);
        enable = 1'b0;
        repeat (120) step();

        chk("final_trig_count", trig_seen, m_trigs);
        chk("final_pv_count", pv_seen, m_pv);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
